decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Parametrised, handshaked RV32I/RV64I/RV32E decode stage. Sits between fetch and execute and registers one decoded instruction per transfer. Outputs class flags, resolved operands, the sign-extended immediate and the branch/jump target. Adds valid/ready backpressure, flush, pc-relative target computation and width/register-count generalisation.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
RF_ADDR_W, 5, register index width; 4 selects RV32E (16 regs).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  fetch offers in_instr/in_pc
in_ready  out  1  stage accepts this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  address of in_instr
flush  in  1  discard held instruction (redirect)
raddr1, raddr2  out  RF_ADDR_W  combinational register read addresses
rdata1, rdata2  in  XLEN  register file data, same cycle as raddr
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute consumes bundle
is_load, is_store, is_ui, add_pc, is_branch, is_jump, is_reg, is_alu  out  1 each  one-hot class flags (is_reg qualifies is_jump; add_pc qualifies is_ui)
operand_a, operand_b  out  XLEN  resolved operands
imm  out  XLEN  sign-extended immediate of the current format
target  out  XLEN  pc+imm for branch/JAL; rs1+imm with bit0 cleared for JALR
out_pc  out  XLEN  pc of held instruction
dest  out  RF_ADDR_W  rd; forced 0 for store/branch
func3  out  3  instr[14:12]
func7  out  1  instr[30]
illegal  out  1  see Optional Feature

Behaviour:
- Reset (clk edge with reset=1): out_valid=0; all flags, operands, imm, target, out_pc, dest, func3, func7 and illegal=0. Reset mid-transfer drops the held bundle.
- in_ready = !flush && (!out_valid || out_ready), purely combinational.
- Accept when in_valid && in_ready: capture all outputs next edge, out_valid=1. Latency is one cycle.
- out_valid && out_ready with no accept: out_valid=0 next edge. Simultaneous consume and accept gives back-to-back throughput.
- out_valid=1 && !out_ready: all outputs hold stable.
- flush=1: out_valid=0 next edge. No accept that cycle; flush wins over in_valid.
- raddr1 = instr[15+:RF_ADDR_W], raddr2 = instr[20+:RF_ADDR_W] from in_instr. Both are 0 during reset.
- Decode per opcode:
  - R-type: a=rs1, b=rs2, is_alu.
  - OP-IMM: a=rs1, b=I-imm, is_alu. For shifts (func3 001/101), b=shamt, zero-extended, $clog2(XLEN) bits wide.
  - LOAD: a=rs1, b=I-imm, is_load.
  - STORE: a=rs1+S-imm, the full XLEN sum with wrap-around; b=rs2; is_store.
  - BRANCH: a=rs1, b=rs2, is_branch, target=pc+B-imm.
  - LUI / AUIPC: a=U-imm, is_ui; add_pc for AUIPC. b=pc for AUIPC, else 0.
  - JAL: is_jump, a=pc+4, target=pc+J-imm.
  - JALR: is_jump, is_reg, a=pc+4, target=(rs1+I-imm)&~1.
  - FENCE / SYSTEM: no flags set; a=rs1, b=I-imm.
  - Unknown opcode: no flags set.
- Every immediate is sign-extended from instr[31] to XLEN. All additions are modulo 2^XLEN.

Optional Feature:
Macro DECODE_ILLEGAL_EN.
- Defined: illegal=1 with the bundle, and all class flags forced 0, for any of:
  - unknown opcode;
  - instr[1:0]!=11;
  - shamt[5]=1 when XLEN=32;
  - any register index bit 4 set when RF_ADDR_W=4;
  - R-type func7 not in {0000000, 0100000}.
- Undefined: illegal is tied to 0; unknown opcodes only clear the flags.

Decomposition:
Package decode_pkg holds the opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM) and the immediate format enum (I/S/B/U/J). One sub-module, imm_gen: combinational, from instr and format to an XLEN immediate.

Test Plan:
- addi x1,x2,-1 (0xFFF10093), rdata1=5, XLEN=32 -> next cycle: out_valid=1, is_alu=1, a=5, b=0xFFFFFFFF, dest=1.
- sw x5,8(x2) (0x00512423), rdata1=0x1000, rdata2=0xAB -> is_store=1, a=0x1008, b=0xAB, dest=0.
- beq x0,x0,-4 (0xFE000EE3) at pc=0x100 -> is_branch=1, imm=0xFFFFFFFC, target=0xFC.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable. Raise out_ready -> the next instruction lands with no bubble.
- Assert flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, input not accepted. Reset mid-stall -> all outputs 0.
- DECODE_ILLEGAL_EN defined, instr 0x00000000 -> illegal=1, all flags 0. Same instr with the macro undefined -> illegal=0. slli with shamt=32 at XLEN=64 -> b=32, illegal=0.

Source files
------------

// File: rtl/decode_pkg.sv
// Opcode constants, immediate formats and the class-flag bundle shared by the decode stage.
package decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    typedef struct packed {
        logic is_load;
        logic is_store;
        logic is_ui;
        logic add_pc;
        logic is_branch;
        logic is_jump;
        logic is_reg;
        logic is_alu;
    } dec_flags_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extractor: picks the bit fields of the selected format
// and sign-extends from instr[31] to XLEN.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  imm_fmt_e        fmt_i,
    output logic [XLEN-1:0] imm_o
);

    always_comb begin
        imm_o = {{(XLEN-11){instr_i[31]}}, instr_i[30:20]};
        case (fmt_i)
            FMT_S:   imm_o = {{(XLEN-11){instr_i[31]}}, instr_i[30:25], instr_i[11:7]};
            FMT_B:   imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
            FMT_U:   imm_o = {{(XLEN-31){instr_i[31]}}, instr_i[30:12], 12'b0};
            FMT_J:   imm_o = {{(XLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
            default: imm_o = {{(XLEN-11){instr_i[31]}}, instr_i[30:20]};
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Single-entry RV32I/RV64I/RV32E decode stage with valid/ready handshake and flush.
// Illegal-instruction detection is built only when DECODE_ILLEGAL_EN is defined.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [XLEN-1:0]      in_pc,
    input  logic                 flush,
    output logic [RF_ADDR_W-1:0] raddr1,
    output logic [RF_ADDR_W-1:0] raddr2,
    input  logic [XLEN-1:0]      rdata1,
    input  logic [XLEN-1:0]      rdata2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 is_load,
    output logic                 is_store,
    output logic                 is_ui,
    output logic                 add_pc,
    output logic                 is_branch,
    output logic                 is_jump,
    output logic                 is_reg,
    output logic                 is_alu,
    output logic [XLEN-1:0]      operand_a,
    output logic [XLEN-1:0]      operand_b,
    output logic [XLEN-1:0]      imm,
    output logic [XLEN-1:0]      target,
    output logic [XLEN-1:0]      out_pc,
    output logic [RF_ADDR_W-1:0] dest,
    output logic [2:0]           func3,
    output logic                 func7,
    output logic                 illegal
);

    localparam int SHW = $clog2(XLEN);

    logic [6:0]           opcode;
    imm_fmt_e             fmt;
    logic [XLEN-1:0]      imm_c;
    logic [XLEN-1:0]      pc_plus4;
    logic [XLEN-1:0]      pc_plus_imm;
    logic [XLEN-1:0]      rs1_plus_imm;
    logic [XLEN-1:0]      shamt;
    dec_flags_t           flags_c;
    dec_flags_t           flags_d;
    dec_flags_t           flags_q;
    logic [XLEN-1:0]      a_d;
    logic [XLEN-1:0]      b_d;
    logic [XLEN-1:0]      tgt_d;
    logic [RF_ADDR_W-1:0] dest_d;
    logic                 illegal_d;
    logic                 valid_q;
    logic [XLEN-1:0]      a_q;
    logic [XLEN-1:0]      b_q;
    logic [XLEN-1:0]      imm_q;
    logic [XLEN-1:0]      tgt_q;
    logic [XLEN-1:0]      pc_q;
    logic [RF_ADDR_W-1:0] dest_q;
    logic [2:0]           func3_q;
    logic                 func7_q;
    logic                 illegal_q;
    logic                 accept;

    assign opcode   = in_instr[6:0];
    assign in_ready = !flush && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign raddr1 = reset ? '0 : in_instr[15 +: RF_ADDR_W];
    assign raddr2 = reset ? '0 : in_instr[20 +: RF_ADDR_W];

    always_comb begin
        fmt = FMT_I;
        case (opcode)
            OP_STORE:         fmt = FMT_S;
            OP_BRANCH:        fmt = FMT_B;
            OP_LUI, OP_AUIPC: fmt = FMT_U;
            OP_JAL:           fmt = FMT_J;
            default:          fmt = FMT_I;
        endcase
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (in_instr),
        .fmt_i   (fmt),
        .imm_o   (imm_c)
    );

    assign pc_plus4     = in_pc + {{(XLEN-3){1'b0}}, 3'd4};
    assign pc_plus_imm  = in_pc + imm_c;
    assign rs1_plus_imm = rdata1 + imm_c;
    assign shamt        = {{(XLEN-SHW){1'b0}}, in_instr[20 +: SHW]};

    // Defaults (a=rs1, b=imm) already cover FENCE, SYSTEM and unknown opcodes.
    always_comb begin
        flags_c = '0;
        a_d     = rdata1;
        b_d     = imm_c;
        tgt_d   = '0;
        dest_d  = in_instr[7 +: RF_ADDR_W];
        case (opcode)
            OP_REG: begin
                flags_c.is_alu = 1'b1;
                b_d            = rdata2;
            end
            OP_IMM: begin
                flags_c.is_alu = 1'b1;
                if (in_instr[13:12] == 2'b01) b_d = shamt;
            end
            OP_LOAD: flags_c.is_load = 1'b1;
            OP_STORE: begin
                flags_c.is_store = 1'b1;
                a_d              = rs1_plus_imm;
                b_d              = rdata2;
                dest_d           = '0;
            end
            OP_BRANCH: begin
                flags_c.is_branch = 1'b1;
                b_d               = rdata2;
                tgt_d             = pc_plus_imm;
                dest_d            = '0;
            end
            OP_LUI: begin
                flags_c.is_ui = 1'b1;
                a_d           = imm_c;
                b_d           = '0;
            end
            OP_AUIPC: begin
                flags_c.is_ui  = 1'b1;
                flags_c.add_pc = 1'b1;
                a_d            = imm_c;
                b_d            = in_pc;
            end
            OP_JAL: begin
                flags_c.is_jump = 1'b1;
                a_d             = pc_plus4;
                tgt_d           = pc_plus_imm;
            end
            OP_JALR: begin
                flags_c.is_jump = 1'b1;
                flags_c.is_reg  = 1'b1;
                a_d             = pc_plus4;
                tgt_d           = {rs1_plus_imm[XLEN-1:1], 1'b0};
            end
            default: ;
        endcase
    end

`ifdef DECODE_ILLEGAL_EN
    logic known_op;
    logic uses_rs1;
    logic uses_rs2;
    logic uses_rd;

    always_comb begin
        known_op = 1'b1;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        uses_rd  = 1'b0;
        case (opcode)
            OP_REG: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                uses_rd  = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                uses_rs1 = 1'b1;
                uses_rd  = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_JAL: uses_rd = 1'b1;
            OP_FENCE, OP_SYSTEM: ;
            default: known_op = 1'b0;
        endcase
    end

    // Only fields that the format actually treats as register indices are checked.
    always_comb begin
        illegal_d = !known_op || (in_instr[1:0] != 2'b11);
        if (XLEN == 32 && opcode == OP_IMM && in_instr[13:12] == 2'b01 && in_instr[25])
            illegal_d = 1'b1;
        if (opcode == OP_REG && in_instr[31:25] != 7'b0000000 && in_instr[31:25] != 7'b0100000)
            illegal_d = 1'b1;
        if (RF_ADDR_W == 4 && ((uses_rs1 && in_instr[19]) || (uses_rs2 && in_instr[24]) ||
                               (uses_rd && in_instr[11])))
            illegal_d = 1'b1;
    end

    assign flags_d = illegal_d ? '0 : flags_c;
`else
    assign illegal_d = 1'b0;
    assign flags_d   = flags_c;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            flags_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            tgt_q     <= '0;
            pc_q      <= '0;
            dest_q    <= '0;
            func3_q   <= '0;
            func7_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            flags_q   <= flags_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_c;
            tgt_q     <= tgt_d;
            pc_q      <= in_pc;
            dest_q    <= dest_d;
            func3_q   <= in_instr[14:12];
            func7_q   <= in_instr[30];
            illegal_q <= illegal_d;
        end else if (flush || out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign is_load   = flags_q.is_load;
    assign is_store  = flags_q.is_store;
    assign is_ui     = flags_q.is_ui;
    assign add_pc    = flags_q.add_pc;
    assign is_branch = flags_q.is_branch;
    assign is_jump   = flags_q.is_jump;
    assign is_reg    = flags_q.is_reg;
    assign is_alu    = flags_q.is_alu;
    assign operand_a = a_q;
    assign operand_b = b_q;
    assign imm       = imm_q;
    assign target    = tgt_q;
    assign out_pc    = pc_q;
    assign dest      = dest_q;
    assign func3     = func3_q;
    assign func7     = func7_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors, handshake stall, flush and reset,
// plus a 64-bit instance for the wide shift-amount case.
module tb_decode_stage;

`ifdef DECODE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    localparam logic [7:0] F_LOAD  = 8'h80;
    localparam logic [7:0] F_STORE = 8'h40;
    localparam logic [7:0] F_UI    = 8'h20;
    localparam logic [7:0] F_APC   = 8'h10;
    localparam logic [7:0] F_BR    = 8'h08;
    localparam logic [7:0] F_J     = 8'h04;
    localparam logic [7:0] F_REG   = 8'h02;
    localparam logic [7:0] F_ALU   = 8'h01;
    // don't-care mask bits for fields the decode leaves unspecified
    localparam logic [3:0] DC_A = 4'h8;
    localparam logic [3:0] DC_B = 4'h4;
    localparam logic [3:0] DC_I = 4'h2;
    localparam logic [3:0] DC_T = 4'h1;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, rdata1, rdata2;
    logic [4:0]  raddr1, raddr2, dest;
    logic        is_load, is_store, is_ui, add_pc, is_branch, is_jump, is_reg, is_alu;
    logic [31:0] operand_a, operand_b, imm, target, out_pc;
    logic [2:0]  func3;
    logic        func7, illegal;

    logic        in_valid64, in_ready64, flush64, out_valid64, out_ready64;
    logic [31:0] in_instr64;
    logic [63:0] in_pc64, rdata1_64, rdata2_64;
    logic [4:0]  raddr1_64, raddr2_64, dest64;
    logic        is_load64, is_store64, is_ui64, add_pc64, is_branch64, is_jump64, is_reg64, is_alu64;
    logic [63:0] operand_a64, operand_b64, imm64, target64, out_pc64;
    logic [2:0]  func3_64;
    logic        func7_64, illegal64;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    decode_stage #(.XLEN(32), .RF_ADDR_W(5)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .out_valid(out_valid), .out_ready(out_ready),
        .is_load(is_load), .is_store(is_store), .is_ui(is_ui), .add_pc(add_pc),
        .is_branch(is_branch), .is_jump(is_jump), .is_reg(is_reg), .is_alu(is_alu),
        .operand_a(operand_a), .operand_b(operand_b), .imm(imm), .target(target),
        .out_pc(out_pc), .dest(dest), .func3(func3), .func7(func7), .illegal(illegal)
    );

    decode_stage #(.XLEN(64), .RF_ADDR_W(5)) u_dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64),
        .in_instr(in_instr64), .in_pc(in_pc64), .flush(flush64),
        .raddr1(raddr1_64), .raddr2(raddr2_64), .rdata1(rdata1_64), .rdata2(rdata2_64),
        .out_valid(out_valid64), .out_ready(out_ready64),
        .is_load(is_load64), .is_store(is_store64), .is_ui(is_ui64), .add_pc(add_pc64),
        .is_branch(is_branch64), .is_jump(is_jump64), .is_reg(is_reg64), .is_alu(is_alu64),
        .operand_a(operand_a64), .operand_b(operand_b64), .imm(imm64), .target(target64),
        .out_pc(out_pc64), .dest(dest64), .func3(func3_64), .func7(func7_64), .illegal(illegal64)
    );

    typedef struct {
        int          id;
        logic [31:0] instr, pc, r1, r2;
        logic [7:0]  flags;
        logic [31:0] a, b, imm, tgt;
        logic [4:0]  dest;
        logic [2:0]  f3;
        logic        f7, ill;
        logic [3:0]  dc;
    } vec_t;

    vec_t sb[$];
    vec_t vt[12];
    int   checks = 0;
    int   failures = 0;
    int   bundles = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(int id, logic [31:0] instr, logic [31:0] pc, logic [31:0] r1,
                                logic [31:0] r2, logic [7:0] fl, logic [31:0] a, logic [31:0] b,
                                logic [31:0] im, logic [31:0] tg, logic [4:0] d, logic [2:0] f3,
                                logic f7, logic ill, logic [3:0] dc);
        vec_t v;
        v.id = id; v.instr = instr; v.pc = pc; v.r1 = r1; v.r2 = r2;
        v.flags = fl; v.a = a; v.b = b; v.imm = im; v.tgt = tg;
        v.dest = d; v.f3 = f3; v.f7 = f7; v.ill = ill; v.dc = dc;
        return v;
    endfunction

    task automatic cmp_bundle(input vec_t e);
        string p;
        p = $sformatf("v%0d", e.id);
        chk({p, ".flags"}, 64'({is_load, is_store, is_ui, add_pc, is_branch, is_jump, is_reg, is_alu}),
            64'(e.flags));
        if (!e.dc[3]) chk({p, ".operand_a"}, 64'(operand_a), 64'(e.a));
        if (!e.dc[2]) chk({p, ".operand_b"}, 64'(operand_b), 64'(e.b));
        if (!e.dc[1]) chk({p, ".imm"}, 64'(imm), 64'(e.imm));
        if (!e.dc[0]) chk({p, ".target"}, 64'(target), 64'(e.tgt));
        chk({p, ".out_pc"}, 64'(out_pc), 64'(e.pc));
        chk({p, ".dest"}, 64'(dest), 64'(e.dest));
        chk({p, ".func3"}, 64'(func3), 64'(e.f3));
        chk({p, ".func7"}, 64'(func7), 64'(e.f7));
        chk({p, ".illegal"}, 64'(illegal), 64'(e.ill));
    endtask

    task automatic monitor();
        vec_t e;
        forever begin
            @(negedge clk);
            if (reset) continue;
            if (out_valid && flush && !out_ready) begin
                if (sb.size() > 0) sb.delete(0);
            end else if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_bundle", 64'(operand_a), 64'hDEAD_0000_0000_0000);
                end else begin
                    e = sb.pop_front();
                    bundles++;
                    cmp_bundle(e);
                end
            end
        end
    endtask

    task automatic send(input vec_t v);
        int   waited;
        logic acc;
        waited = 0;
        in_valid = 1'b1;
        in_instr = v.instr;
        in_pc    = v.pc;
        rdata1   = v.r1;
        rdata2   = v.r2;
        sb.push_back(v);
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 50) begin
                chk("send_timeout", 64'(waited), 64'(0));
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, ".flags"}, 64'({is_load, is_store, is_ui, add_pc, is_branch, is_jump, is_reg, is_alu}),
            64'(0));
        chk({tag, ".operand_a"}, 64'(operand_a), 64'(0));
        chk({tag, ".operand_b"}, 64'(operand_b), 64'(0));
        chk({tag, ".imm"}, 64'(imm), 64'(0));
        chk({tag, ".target"}, 64'(target), 64'(0));
        chk({tag, ".out_pc"}, 64'(out_pc), 64'(0));
        chk({tag, ".dest_f3_f7_ill"}, 64'({dest, func3, func7, illegal}), 64'(0));
        chk({tag, ".raddr"}, 64'({raddr1, raddr2}), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t a, b, d, e;
        int   c0, c1;

        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_instr = 32'hFFF10093; in_pc = '0; rdata1 = '0; rdata2 = '0;
        in_valid64 = 1'b0; flush64 = 1'b0; out_ready64 = 1'b1;
        in_instr64 = '0; in_pc64 = '0; rdata1_64 = '0; rdata2_64 = '0;

        vt[0]  = mk(1,  32'hFFF10093, 32'h000, 32'h5,        32'h77, F_ALU,   32'h5,        32'hFFFFFFFF,
                    32'hFFFFFFFF, 32'h0,   5'd1,  3'd0, 1'b1, 1'b0, DC_T);
        vt[1]  = mk(2,  32'h00512423, 32'h004, 32'h1000,     32'hAB, F_STORE, 32'h1008,     32'hAB,
                    32'h8,        32'h0,   5'd0,  3'd2, 1'b0, 1'b0, DC_T);
        vt[2]  = mk(3,  32'hFE000EE3, 32'h100, 32'h11,       32'h22, F_BR,    32'h11,       32'h22,
                    32'hFFFFFFFC, 32'hFC,  5'd0,  3'd0, 1'b1, 1'b0, 4'h0);
        vt[3]  = mk(4,  32'h405201B3, 32'h104, 32'd10,       32'd3,  F_ALU,   32'd10,       32'd3,
                    32'h0,        32'h0,   5'd3,  3'd0, 1'b1, 1'b0, DC_I | DC_T);
        vt[4]  = mk(5,  32'h4033D313, 32'h108, 32'h80000000, 32'h55, F_ALU,   32'h80000000, 32'd3,
                    32'h403,      32'h0,   5'd6,  3'd5, 1'b1, 1'b0, DC_T);
        vt[5]  = mk(6,  32'hFF04A403, 32'h10C, 32'h2000,     32'h0,  F_LOAD,  32'h2000,     32'hFFFFFFF0,
                    32'hFFFFFFF0, 32'h0,   5'd8,  3'd2, 1'b1, 1'b0, DC_T);
        vt[6]  = mk(7,  32'h12345537, 32'h110, 32'h99,       32'h0,  F_UI,    32'h12345000, 32'h0,
                    32'h12345000, 32'h0,   5'd10, 3'd5, 1'b0, 1'b0, DC_T);
        vt[7]  = mk(8,  32'hFFFFF597, 32'h400, 32'h0,        32'h0,  F_UI | F_APC, 32'hFFFFF000, 32'h400,
                    32'hFFFFF000, 32'h0,   5'd11, 3'd7, 1'b1, 1'b0, DC_T);
        vt[8]  = mk(9,  32'hFF9FF0EF, 32'h200, 32'h0,        32'h0,  F_J,     32'h204,      32'h0,
                    32'hFFFFFFF8, 32'h1F8, 5'd1,  3'd7, 1'b1, 1'b0, DC_B);
        vt[9]  = mk(10, 32'h00428067, 32'h500, 32'h303,      32'h0,  F_J | F_REG, 32'h504,  32'h0,
                    32'h4,        32'h306, 5'd0,  3'd0, 1'b0, 1'b0, DC_B);
        vt[10] = mk(11, 32'h00000000, 32'h504, 32'h0,        32'h0,  8'h00,   32'h0,        32'h0,
                    32'h0,        32'h0,   5'd0,  3'd0, 1'b0, ILL_EN, DC_A | DC_B | DC_I | DC_T);
        vt[11] = mk(12, 32'h02009093, 32'h508, 32'h7,        32'h0,  ILL_EN ? 8'h00 : F_ALU,
                    32'h7, 32'h0, 32'h20, 32'h0, 5'd1, 3'd1, 1'b0, ILL_EN, DC_T);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        chk("reset.in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("raddr1", 64'(raddr1), 64'(2));
        chk("raddr2", 64'(raddr2), 64'(31));

        fork
            monitor();
        join_none

        @(posedge clk); #1;
        c0 = cyc;
        for (int i = 0; i < 12; i++) send(vt[i]);
        c1 = cyc;
        chk("burst_cycles", 64'(c1 - c0), 64'(12));
        repeat (2) @(posedge clk);
        #1;

        // stall: A held while B waits, then B follows without a bubble
        out_ready = 1'b0;
        a = vt[0]; a.id = 13;
        send(a);
        b = vt[1]; b.id = 14;
        in_valid = 1'b1; in_instr = b.instr; in_pc = b.pc; rdata1 = b.r1; rdata2 = b.r2;
        sb.push_back(b);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall.in_ready", 64'(in_ready), 64'(0));
            chk("stall.out_valid", 64'(out_valid), 64'(1));
            chk("stall.operand_a", 64'(operand_a), 64'(32'h5));
            chk("stall.operand_b", 64'(operand_b), 64'(32'hFFFFFFFF));
            chk("stall.dest", 64'(dest), 64'(1));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("no_bubble.out_valid", 64'(out_valid), 64'(1));
        chk("no_bubble.operand_a", 64'(operand_a), 64'(32'h1008));
        @(posedge clk); #1;

        // flush while holding a bundle and offering a new one
        out_ready = 1'b0;
        d = vt[2]; d.id = 15;
        send(d);
        in_valid = 1'b1; in_instr = vt[6].instr; in_pc = vt[6].pc;
        flush = 1'b1;
        @(negedge clk);
        chk("flush.in_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush.out_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;

        // reset during a stall drops the held bundle
        e = vt[8]; e.id = 16;
        send(e);
        in_valid = 1'b1; in_instr = 32'hFFF10093;
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_state("mid_reset");
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

        // 64-bit slli by 32 keeps the full 6-bit shift amount
        in_valid64 = 1'b1; in_instr64 = 32'h02009093; in_pc64 = 64'h1000; rdata1_64 = 64'h1;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        @(negedge clk);
        chk("x64.out_valid", 64'(out_valid64), 64'(1));
        chk("x64.operand_b", operand_b64, 64'd32);
        chk("x64.illegal", 64'(illegal64), 64'(0));
        chk("x64.is_alu", 64'(is_alu64), 64'(1));

        repeat (5) @(posedge clk);
        chk("sb_drain", 64'(sb.size()), 64'(0));
        chk("bundles_compared", 64'(bundles), 64'(14));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
